// File: rtl/kfpc_dma_arbiter_pkg.sv
// Shared types and constants for the 8088/DMA bus arbiter and its XT page registers.
package kfpc_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StGrant,
    StRelease
  } arb_state_e;

  // XT page-register I/O offsets within 0x80-0x87.
  localparam logic [2:0] PageAddrCh0 = 3'd7;
  localparam logic [2:0] PageAddrCh1 = 3'd3;
  localparam logic [2:0] PageAddrCh2 = 3'd1;
  localparam logic [2:0] PageAddrCh3 = 3'd2;

  // Returns {valid, channel[1:0]} for a page-register I/O offset.
  function automatic logic [2:0] page_channel(input logic [2:0] addr);
    logic [2:0] result;
    case (addr)
      PageAddrCh0: result = {1'b1, 2'd0};
      PageAddrCh1: result = {1'b1, 2'd1};
      PageAddrCh2: result = {1'b1, 2'd2};
      PageAddrCh3: result = {1'b1, 2'd3};
      default:     result = 3'b000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/kfpc_dma_page_registers.sv
// XT DMA page registers: edge-detected CPU writes, channel mux on DACK, optional readback
// (enabled by KFPC_DMA_PAGE_READBACK_EN).
module kfpc_dma_page_registers
  import kfpc_dma_arbiter_pkg::*;
#(
  parameter int unsigned PAGE_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  page_cs_n,
  input  logic [2:0]            page_address,
  input  logic                  io_write_n,
  input  logic                  io_read_n,
  input  logic [7:0]            data_bus_in,
  input  logic                  bus_owner,
  input  logic [3:0]            dma_acknowledge,
  output logic [PAGE_WIDTH-1:0] page_select,
  output logic [7:0]            data_bus_out
);

  logic [PAGE_WIDTH-1:0] page_q [4];
  logic                  write_n_q;
  logic [2:0]            map;
  logic                  write_stb;

  assign map = page_channel(page_address);
  // One write per strobe: only the first low cycle after io_write_n was high counts.
  assign write_stb = ~page_cs_n & ~io_write_n & write_n_q & ~bus_owner & map[2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_n_q <= 1'b1;
      for (int i = 0; i < 4; i++) page_q[i] <= '0;
    end else begin
      write_n_q <= io_write_n;
      if (write_stb) page_q[map[1:0]] <= data_bus_in[PAGE_WIDTH-1:0];
    end
  end

  // Lowest set DACK bit wins.
  always_comb begin
    page_select = '0;
    if (dma_acknowledge[0])      page_select = page_q[0];
    else if (dma_acknowledge[1]) page_select = page_q[1];
    else if (dma_acknowledge[2]) page_select = page_q[2];
    else if (dma_acknowledge[3]) page_select = page_q[3];
  end

`ifdef KFPC_DMA_PAGE_READBACK_EN
  logic [7:0] read_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_q <= 8'h00;
    end else if (~page_cs_n & ~io_read_n) begin
      read_q <= map[2] ? 8'(page_q[map[1:0]]) : 8'h00;
    end
  end

  assign data_bus_out = read_q;
`else
  logic unused_read;
  assign unused_read  = io_read_n;
  assign data_bus_out = 8'h00;
`endif

  logic unused_data;
  assign unused_data = ^data_bus_in;

endmodule

// File: rtl/kfpc_dma_bus_arbiter.sv
// 8088/DMA system-bus handover FSM with XT page-register address extension.
// Page readback is enabled by defining KFPC_DMA_PAGE_READBACK_EN.
module kfpc_dma_bus_arbiter
  import kfpc_dma_arbiter_pkg::*;
#(
  parameter int unsigned SYNC_CYCLES    = 2,
  parameter int unsigned RELEASE_CYCLES = 1,
  parameter int unsigned PAGE_WIDTH     = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   page_cs_n,
  input  logic [2:0]             page_address,
  input  logic                   io_write_n,
  input  logic                   io_read_n,
  input  logic [7:0]             data_bus_in,
  output logic [7:0]             data_bus_out,
  input  logic                   hold_request,
  input  logic                   cpu_bus_idle,
  input  logic                   cpu_lock_n,
  output logic                   hold_acknowledge,
  output logic                   dma_bus_owner,
  input  logic [3:0]             dma_acknowledge,
  input  logic [15:0]            dma_address_in,
  output logic [16+PAGE_WIDTH-1:0] dma_address_out
);

  localparam logic [3:0] SyncMax = 4'(SYNC_CYCLES);
  localparam logic [3:0] RelMax  = 4'(RELEASE_CYCLES);

  arb_state_e            state_q, state_d;
  logic [3:0]            sync_cnt_q, sync_cnt_d;
  logic [3:0]            rel_cnt_q, rel_cnt_d;
  logic                  hlda_q, hlda_d;
  logic                  owner_q, owner_d;
  logic [PAGE_WIDTH-1:0] page_select;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sync_cnt_q <= '0;
      rel_cnt_q  <= '0;
      hlda_q     <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      hlda_q     <= hlda_d;
      owner_q    <= owner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    hlda_d     = hlda_q;
    owner_d    = owner_q;
    unique case (state_q)
      StIdle: begin
        if (hold_request) begin
          state_d    = StSync;
          sync_cnt_d = '0;
        end
      end
      StSync: begin
        if (!hold_request) begin
          state_d = StIdle;
        end else if (sync_cnt_q == SyncMax) begin
          state_d = StGrant;
          hlda_d  = 1'b1;
          owner_d = 1'b1;
        end else if (cpu_bus_idle && cpu_lock_n) begin
          sync_cnt_d = sync_cnt_q + 4'd1;
        end else begin
          sync_cnt_d = '0;
        end
      end
      StGrant: begin
        if (!hold_request) begin
          hlda_d    = 1'b0;
          rel_cnt_d = '0;
          if (RelMax == 4'd0) begin
            owner_d = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StRelease;
          end
        end
      end
      StRelease: begin
        // Turnaround: keep CPU drivers off the bus; a new request waits for IDLE.
        if ((rel_cnt_q + 4'd1) >= RelMax) begin
          owner_d = 1'b0;
          state_d = StIdle;
        end else begin
          rel_cnt_d = rel_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign hold_acknowledge = hlda_q;
  assign dma_bus_owner    = owner_q;
  assign dma_address_out  = {page_select, dma_address_in};

  kfpc_dma_page_registers #(
    .PAGE_WIDTH(PAGE_WIDTH)
  ) u_page_registers (
    .clock           (clock),
    .reset_n         (reset_n),
    .page_cs_n       (page_cs_n),
    .page_address    (page_address),
    .io_write_n      (io_write_n),
    .io_read_n       (io_read_n),
    .data_bus_in     (data_bus_in),
    .bus_owner       (owner_q),
    .dma_acknowledge (dma_acknowledge),
    .page_select     (page_select),
    .data_bus_out    (data_bus_out)
  );

endmodule

// File: tb/tb_kfpc_dma_bus_arbiter.sv
// Directed self-checking bench for kfpc_dma_bus_arbiter (default parameters).
module tb_kfpc_dma_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        page_cs_n = 1'b1;
  logic [2:0]  page_address = 3'd0;
  logic        io_write_n = 1'b1;
  logic        io_read_n = 1'b1;
  logic [7:0]  data_bus_in = 8'h00;
  logic [7:0]  data_bus_out;
  logic        hold_request = 1'b0;
  logic        cpu_bus_idle = 1'b0;
  logic        cpu_lock_n = 1'b1;
  logic        hold_acknowledge;
  logic        dma_bus_owner;
  logic [3:0]  dma_acknowledge = 4'b0000;
  logic [15:0] dma_address_in = 16'h0000;
  logic [19:0] dma_address_out;

  int n_checks = 0;
  int n_fail = 0;
  int saw_grant;

  kfpc_dma_bus_arbiter dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .page_cs_n        (page_cs_n),
    .page_address     (page_address),
    .io_write_n       (io_write_n),
    .io_read_n        (io_read_n),
    .data_bus_in      (data_bus_in),
    .data_bus_out     (data_bus_out),
    .hold_request     (hold_request),
    .cpu_bus_idle     (cpu_bus_idle),
    .cpu_lock_n       (cpu_lock_n),
    .hold_acknowledge (hold_acknowledge),
    .dma_bus_owner    (dma_bus_owner),
    .dma_acknowledge  (dma_acknowledge),
    .dma_address_in   (dma_address_in),
    .dma_address_out  (dma_address_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic page_write(input logic [2:0] addr, input logic [7:0] data);
    page_cs_n    = 1'b0;
    page_address = addr;
    data_bus_in  = data;
    io_write_n   = 1'b0;
    tick();
    io_write_n = 1'b1;
    page_cs_n  = 1'b1;
    tick();
  endtask

  task automatic addr_check(input string tag, input logic [3:0] dack, input logic [19:0] exp);
    dma_acknowledge = dack;
    #1;
    check(tag, dma_address_out, exp);
  endtask

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    hold_request = 1'b1;
    #2;
    check("rst_hlda", 20'(hold_acknowledge), 20'd0);
    check("rst_owner", 20'(dma_bus_owner), 20'd0);
    check("rst_addr", dma_address_out, 20'h00000);
    check("rst_rdata", 20'(data_bus_out), 20'd0);
    cpu_bus_idle = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    tick();  // IDLE -> SYNC
    check("lat_e0", 20'(hold_acknowledge), 20'd0);
    tick();
    check("lat_e1", 20'(hold_acknowledge), 20'd0);
    tick();
    check("lat_e2", 20'(hold_acknowledge), 20'd0);
    tick();
    check("lat_e3_hlda", 20'(hold_acknowledge), 20'd1);
    check("lat_e3_owner", 20'(dma_bus_owner), 20'd1);

    // Release handover
    hold_request = 1'b0;
    tick();
    check("rel_hlda", 20'(hold_acknowledge), 20'd0);
    check("rel_owner_hold", 20'(dma_bus_owner), 20'd1);
    tick();
    check("rel_owner_drop", 20'(dma_bus_owner), 20'd0);

    // Idle gating: 1,0,1,1
    cpu_bus_idle = 1'b0;
    hold_request = 1'b1;
    tick();
    cpu_bus_idle = 1'b1; tick();
    check("gate_1", 20'(hold_acknowledge), 20'd0);
    cpu_bus_idle = 1'b0; tick();
    check("gate_0", 20'(hold_acknowledge), 20'd0);
    cpu_bus_idle = 1'b1; tick();
    check("gate_1b", 20'(hold_acknowledge), 20'd0);
    tick();
    check("gate_1c", 20'(hold_acknowledge), 20'd0);
    tick();
    check("gate_grant", 20'(hold_acknowledge), 20'd1);
    hold_request = 1'b0;
    tick(); tick();

    // LOCK# blocks grant
    cpu_lock_n   = 1'b0;
    hold_request = 1'b1;
    saw_grant    = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hold_acknowledge || dma_bus_owner) saw_grant++;
    end
    check("lock_no_grant", 20'(saw_grant), 20'd0);
    cpu_lock_n = 1'b1;
    tick(); tick();
    check("unlock_wait", 20'(hold_acknowledge), 20'd0);
    tick();
    check("unlock_grant", 20'(hold_acknowledge), 20'd1);
    hold_request = 1'b0;
    tick(); tick();

    // Drop in SYNC: never granted
    hold_request = 1'b1;
    tick(); tick();
    hold_request = 1'b0;
    saw_grant = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (hold_acknowledge || dma_bus_owner) saw_grant++;
    end
    check("sync_abort", 20'(saw_grant), 20'd0);

    // Page mapping
    dma_address_in = 16'h1234;
    page_write(3'd3, 8'h0A);
    page_write(3'd1, 8'h05);
    addr_check("map_ch1", 4'b0010, 20'hA1234);
    addr_check("map_ch2", 4'b0100, 20'h51234);
    addr_check("map_prio", 4'b0110, 20'hA1234);
    addr_check("map_none", 4'b0000, 20'h01234);

    // Long write strobe stores only the first cycle's data
    page_cs_n = 1'b0; page_address = 3'd7; data_bus_in = 8'h03; io_write_n = 1'b0;
    tick();
    data_bus_in = 8'h0F;
    tick(); tick(); tick();
    io_write_n = 1'b1; page_cs_n = 1'b1;
    tick();
    addr_check("single_write", 4'b0001, 20'h31234);

    // Writes ignored while DMA owns the bus
    hold_request = 1'b1;
    tick(); tick(); tick(); tick();
    check("own_grant", 20'(dma_bus_owner), 20'd1);
    page_write(3'd3, 8'h07);
    addr_check("own_blocked", 4'b0010, 20'hA1234);
    hold_request = 1'b0;
    tick(); tick();

    // Unmapped address
    page_write(3'd5, 8'h09);
    addr_check("unmap_ch0", 4'b0001, 20'h31234);
    addr_check("unmap_ch1", 4'b0010, 20'hA1234);
    addr_check("unmap_ch2", 4'b0100, 20'h51234);
    addr_check("unmap_ch3", 4'b1000, 20'h01234);

    // Same-edge write and DACK: old value until the edge
    page_cs_n = 1'b0; page_address = 3'd2; data_bus_in = 8'h06; io_write_n = 1'b0;
    #1;
    check("same_edge_old", dma_address_out, 20'h01234);
    tick();
    check("same_edge_new", dma_address_out, 20'h61234);
    io_write_n = 1'b1; page_cs_n = 1'b1;
    tick();

    // Readback
    page_write(3'd7, 8'h3C);
    addr_check("ch0_3c", 4'b0001, 20'hC1234);
    page_cs_n = 1'b0; page_address = 3'd7; io_read_n = 1'b0;
    tick();
`ifdef KFPC_DMA_PAGE_READBACK_EN
    check("readback_ch0", 20'(data_bus_out), 20'h0C);
`else
    check("readback_off", 20'(data_bus_out), 20'h00);
`endif
    page_address = 3'd5;
    tick();
    check("readback_unmapped", 20'(data_bus_out), 20'h00);
    page_address = 3'd7;
    tick();
    io_read_n = 1'b1; page_cs_n = 1'b1;

    // Mid-operation asynchronous reset during GRANT
    hold_request = 1'b1;
    tick(); tick(); tick(); tick();
    check("pre_rst_grant", 20'(hold_acknowledge), 20'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_hlda", 20'(hold_acknowledge), 20'd0);
    check("async_owner", 20'(dma_bus_owner), 20'd0);
    check("async_page", dma_address_out, 20'h01234);
    check("async_rdata", 20'(data_bus_out), 20'h00);
    hold_request = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    addr_check("post_rst_ch1", 4'b0010, 20'h01234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
